// File: rtl/truth_table_sequencer_if.sv
// Board-side bundle for the truth-table exerciser: run control, gate stimulus/response
// and the result registers shown on LEDs.
interface truth_table_sequencer_if #(
    parameter int N_IN = 4
);
    logic            start;
    logic            z;
    logic [N_IN-1:0] x;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] fail_vec;

    modport master (
        output start, z,
        input  x, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        input  start, z,
        output x, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/truth_table_sequencer.sv
// Walks a gate under test through every input combination, samples its synchronised
// output at the end of each dwell and scores it against the EXPECTED truth table.
module truth_table_sequencer #(
    parameter int                    N_IN     = 4,
    parameter logic [(1<<N_IN)-1:0]  EXPECTED = 16'h8000,
    parameter int                    DWELL    = 42
) (
    input  logic                  clk,
    input  logic                  rstn,
    truth_table_sequencer_if.slave io
);
    localparam int              DW        = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0]   DWELL_END = DW'(DWELL - 1);
    localparam logic [N_IN-1:0] X_LAST    = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_APPLY, ST_DONE} state_t;

    state_t          state, state_nxt;
    logic [1:0]      z_sync;
    logic            z_s;
    logic [DW-1:0]   dwell, dwell_nxt;
    logic [N_IN-1:0] x_q, x_nxt;
    logic [N_IN-1:0] fail_q, fail_nxt;
    logic [N_IN:0]   err_q, err_nxt, err_new;
    logic            busy_q, busy_nxt;
    logic            done_q, done_nxt;
    logic            pass_q, pass_nxt;
    logic            mismatch;

    assign z_s = z_sync[1];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            z_sync <= '0;
            dwell  <= '0;
            x_q    <= '0;
            fail_q <= '0;
            err_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            z_sync <= {z_sync[0], io.z};
            dwell  <= dwell_nxt;
            x_q    <= x_nxt;
            fail_q <= fail_nxt;
            err_q  <= err_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            pass_q <= pass_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dwell_nxt = dwell;
        x_nxt     = x_q;
        fail_nxt  = fail_q;
        err_nxt   = err_q;
        busy_nxt  = busy_q;
        done_nxt  = done_q;
        pass_nxt  = pass_q;
        mismatch  = (z_s != EXPECTED[x_q]);
        err_new   = err_q + {{N_IN{1'b0}}, mismatch};

        case (state)
            ST_IDLE, ST_DONE: begin
                if (io.start) begin
                    state_nxt = ST_APPLY;
                    dwell_nxt = '0;
                    x_nxt     = '0;
                    fail_nxt  = '0;
                    err_nxt   = '0;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    pass_nxt  = 1'b0;
                end
            end
            ST_APPLY: begin
                if (dwell == DWELL_END) begin
                    // Sample point: z_s has had >= 2 sync stages + 1 settle cycle on this x.
                    err_nxt   = err_new;
                    dwell_nxt = '0;
                    if (mismatch && (err_q == '0))
                        fail_nxt = x_q;
                    if (x_q == X_LAST) begin
                        state_nxt = ST_DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        pass_nxt  = (err_new == '0);
                        x_nxt     = '0;
                    end else begin
                        x_nxt = x_q + N_IN'(1);
                    end
                end else begin
                    dwell_nxt = dwell + DW'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign io.x         = x_q;
    assign io.busy      = busy_q;
    assign io.done      = done_q;
    assign io.pass      = pass_q;
    assign io.err_count = err_q;
    assign io.fail_vec  = fail_q;
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench: table of gate models scored by a DWELL=4 sequencer, plus hand-written
// sequences for held start, mid-run reset and a delayed gate on a DWELL=3 sequencer.
module tb_truth_table_sequencer;
    logic clk;
    logic rstn;
    int   mode;
    int   n_checks = 0;
    int   n_fail   = 0;

    truth_table_sequencer_if #(.N_IN(4)) ifm ();
    truth_table_sequencer_if #(.N_IN(4)) if3 ();

    truth_table_sequencer #(.N_IN(4), .EXPECTED(16'h8000), .DWELL(4)) u_dut (
        .clk (clk),
        .rstn(rstn),
        .io  (ifm)
    );

    truth_table_sequencer #(.N_IN(4), .EXPECTED(16'h8000), .DWELL(3)) u_dut3 (
        .clk (clk),
        .rstn(rstn),
        .io  (if3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate models: 0 = AND4, 1 = stuck at 0, 2 = OR4
    always_comb begin
        case (mode)
            1:       ifm.z = 1'b0;
            2:       ifm.z = |ifm.x;
            default: ifm.z = &ifm.x;
        endcase
    end

    // AND4 whose output lags its inputs by almost a full clock period
    initial if3.z = 1'b0;
    always begin
        @(if3.x);
        #9;
        if3.z = &if3.x;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Launch a run on the DWELL=4 instance and follow it until done rises.
    task automatic run(input bit hold, output int busy_cyc, output bit x_ok, output bit timeout);
        @(negedge clk) ifm.start = 1'b1;
        @(negedge clk) if (!hold) ifm.start = 1'b0;
        busy_cyc = 0;
        x_ok     = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (ifm.done === 1'b1) break;
            if (ifm.busy === 1'b1) begin
                if (ifm.x !== 4'(busy_cyc / 4)) x_ok = 1'b0;
                busy_cyc++;
            end
            @(negedge clk);
        end
        timeout = (ifm.done !== 1'b1);
    endtask

    typedef struct {
        string name;
        int    mode;
        int    exp_err;
        int    exp_fail;
        bit    exp_pass;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int busy_cyc;
        bit x_ok;
        bit timeout;
        int cnt;

        vecs[0] = '{"and4", 0, 0,  0,  1'b1};
        vecs[1] = '{"zero", 1, 1,  15, 1'b0};
        vecs[2] = '{"or4",  2, 14, 1,  1'b0};

        mode      = 0;
        ifm.start = 1'b0;
        if3.start = 1'b0;
        rstn      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_x",    32'(ifm.x),         0);
        check("rst_busy", 32'(ifm.busy),      0);
        check("rst_done", 32'(ifm.done),      0);
        check("rst_pass", 32'(ifm.pass),      0);
        check("rst_err",  32'(ifm.err_count), 0);
        check("rst_fail", 32'(ifm.fail_vec),  0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            mode = vecs[i].mode;
            run(1'b0, busy_cyc, x_ok, timeout);
            check({vecs[i].name, "_timeout"}, 32'(timeout),           0);
            check({vecs[i].name, "_busy"},    32'(busy_cyc),          64);
            check({vecs[i].name, "_xstep"},   32'(x_ok),              1);
            check({vecs[i].name, "_done"},    32'(ifm.done),          1);
            check({vecs[i].name, "_pass"},    32'(ifm.pass),          32'(vecs[i].exp_pass));
            check({vecs[i].name, "_err"},     32'(ifm.err_count),     32'(vecs[i].exp_err));
            if (vecs[i].exp_err != 0)
                check({vecs[i].name, "_fvec"}, 32'(ifm.fail_vec),     32'(vecs[i].exp_fail));
            check({vecs[i].name, "_xzero"},   32'(ifm.x),             0);
            // Results must stay put while idle in DONE
            repeat (5) @(negedge clk);
            check({vecs[i].name, "_hold_done"}, 32'(ifm.done),        1);
            check({vecs[i].name, "_hold_err"},  32'(ifm.err_count),   32'(vecs[i].exp_err));
        end

        // Delayed gate on the DWELL=3 instance
        @(negedge clk) if3.start = 1'b1;
        @(negedge clk) if3.start = 1'b0;
        cnt = 0;
        for (int c = 0; c < 300; c++) begin
            if (if3.done === 1'b1) break;
            if (if3.busy === 1'b1) cnt++;
            @(negedge clk);
        end
        check("dly_busy", 32'(cnt),           48);
        check("dly_done", 32'(if3.done),      1);
        check("dly_pass", 32'(if3.pass),      1);
        check("dly_err",  32'(if3.err_count), 0);

        // start held high: no restart while busy, relaunch on the first DONE cycle
        mode = 1;
        run(1'b1, busy_cyc, x_ok, timeout);
        check("hold_timeout", 32'(timeout),       0);
        check("hold_busy",    32'(busy_cyc),      64);
        check("hold_xstep",   32'(x_ok),          1);
        check("hold_err",     32'(ifm.err_count), 1);
        check("hold_fvec",    32'(ifm.fail_vec),  15);
        @(negedge clk);
        check("relaunch_busy", 32'(ifm.busy),      1);
        check("relaunch_done", 32'(ifm.done),      0);
        check("relaunch_err",  32'(ifm.err_count), 0);
        check("relaunch_fvec", 32'(ifm.fail_vec),  0);
        check("relaunch_x",    32'(ifm.x),         0);
        ifm.start = 1'b0;

        // Reset in the middle of a run while x == 7
        cnt = 0;
        while (ifm.x !== 4'd7 && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("wait_x7", 32'(ifm.x), 7);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("mrst_x",    32'(ifm.x),         0);
        check("mrst_busy", 32'(ifm.busy),      0);
        check("mrst_done", 32'(ifm.done),      0);
        check("mrst_pass", 32'(ifm.pass),      0);
        check("mrst_err",  32'(ifm.err_count), 0);
        check("mrst_fvec", 32'(ifm.fail_vec),  0);
        repeat (3) @(negedge clk);
        check("mrst_idle", 32'(ifm.busy),      0);
        mode = 0;
        run(1'b0, busy_cyc, x_ok, timeout);
        check("post_timeout", 32'(timeout),       0);
        check("post_busy",    32'(busy_cyc),      64);
        check("post_xstep",   32'(x_ok),          1);
        check("post_pass",    32'(ifm.pass),      1);
        check("post_err",     32'(ifm.err_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
